// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALUOp encodings, opcode constants and decoder control bundle
package pipe_pkg;
  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_R = 2'b10;
  localparam logic [1:0] ALU_I = 2'b11;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_VECTOR = 7'b1010111;
  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic       imm_select;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detection between EX load and ID consumer (VECTOR_STAGE_EN exempts vector ops)
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_vector,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);
  logic id_vec;
  logic rs2_used;
  always_comb begin
`ifdef VECTOR_STAGE_EN
    id_vec = id_opcode == OP_VECTOR;
`else
    id_vec = 1'b0;
`endif
    rs2_used = (id_opcode == OP_R) | (id_opcode == OP_STORE) | (id_opcode == OP_BRANCH) | id_vec;
    load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & ~id_vec & ~ex_vector &
               ((ex_rd == id_rs1) | (rs2_used & (ex_rd == id_rs2)));
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble FSM; VECTOR_STAGE_EN adds is_vector_o
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            MemtoReg_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic            RegWrite_i,
  input  logic            ALUSrc_i,
  input  logic            immSelect_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [6:0]      opcode_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic            flush_i,
  output logic            MemtoReg_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            RegWrite_o,
  output logic            ALUSrc_o,
  output logic            immSelect_o,
  output logic [1:0]      ALUOp_o,
  output logic [6:0]      opcode_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            valid_o,
`ifdef VECTOR_STAGE_EN
  output logic            is_vector_o,
`endif
  output logic            stall_o
);
  typedef enum logic {RUN, BUBBLE} state_e;
  state_e state_q, state_d;
  ctrl_t  ctrl_d, ctrl_q;
  logic   load_use, kill, ex_vector;
`ifdef VECTOR_STAGE_EN
  assign ex_vector = is_vector_o;
`else
  assign ex_vector = 1'b0;
`endif
  hazard_detect u_hazard (
    .ex_valid   (valid_o),
    .ex_mem_read(MemRead_o),
    .ex_vector  (ex_vector),
    .ex_rd      (rd_addr_o),
    .id_valid   (valid_i),
    .id_opcode  (opcode_i),
    .id_rs1     (rs1_addr_i),
    .id_rs2     (rs2_addr_i),
    .load_use   (load_use)
  );
  always_comb begin
    stall_o = (state_q == RUN) & load_use & ~flush_i;
    state_d = stall_o ? BUBBLE : RUN;
    kill    = flush_i | stall_o;
    ctrl_d  = valid_i ? {MemtoReg_i, MemRead_i, MemWrite_i, RegWrite_i, ALUSrc_i, immSelect_i, ALUOp_i} : '0;
  end
  assign {MemtoReg_o, MemRead_o, MemWrite_o, RegWrite_o, ALUSrc_o, immSelect_o, ALUOp_o} = ctrl_q;
  // killed entries zero control and valid but leave the datapath fields untouched
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      valid_o    <= 1'b0;
      ctrl_q     <= '0;
      opcode_o   <= '0;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      rd_addr_o  <= '0;
      funct3_o   <= '0;
      funct7_o   <= '0;
    end else begin
      state_q <= state_d;
      valid_o <= valid_i & ~kill;
      ctrl_q  <= kill ? '0 : ctrl_d;
      if (!kill) begin
        opcode_o   <= opcode_i;
        pc_o       <= pc_i;
        rs1_data_o <= rs1_data_i;
        rs2_data_o <= rs2_data_i;
        imm_o      <= imm_i;
        rs1_addr_o <= rs1_addr_i;
        rs2_addr_o <= rs2_addr_i;
        rd_addr_o  <= rd_addr_i;
        funct3_o   <= funct3_i;
        funct7_o   <= funct7_i;
      end
    end
  end
`ifdef VECTOR_STAGE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) is_vector_o <= 1'b0;
    else is_vector_o <= ~kill & valid_i & (opcode_i == OP_VECTOR);
  end
`endif
endmodule
